// File: rtl/axi4_mgr_sched_pkg.sv
// Shared types for the AXI4 manager scheduler.
package axi4_mgr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi4_mgr_sched_chan.sv
// One direction of the scheduler: round-robin grant, command latches and
// the IDLE -> ISSUE -> BUSY -> DONE handshake with the shared manager.
module axi4_mgr_sched_chan
  import axi4_mgr_sched_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8,
  localparam int CID_W      = $clog2(NUM_CLIENTS)
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NUM_CLIENTS-1:0]              cmd_valid_i,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  cmd_addr_i,
  input  logic [NUM_CLIENTS-1:0][CNT_W-1:0]   cmd_count_i,
  output logic [NUM_CLIENTS-1:0]              cmd_ready_o,
  output logic [NUM_CLIENTS-1:0]              done_o,
  output logic [1:0]                          done_err_o,
  output logic                                mgr_req_o,
  output logic [ADDR_W-1:0]                   mgr_addr_o,
  output logic [CNT_W-1:0]                    mgr_count_o,
  input  logic                                mgr_rsp_i,
  input  logic [1:0]                          mgr_err_i,
  output logic                                busy_o,
  output logic [CID_W-1:0]                    owner_o
);

  sched_state_t      state_q, state_d;
  logic [CID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CID_W-1:0]  owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        err_q, err_d;
  logic [CID_W-1:0]  grant, idx;
  logic              found;

  // First valid client at or after rr_ptr, wrapping around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = CID_W'((int'(rr_ptr_q) + i) % NUM_CLIENTS);
      if (!found && cmd_valid_i[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Next-state and handshake outputs; latches clear on the way back to IDLE
  // so the manager-facing address/count read 0 while idle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    cmd_ready_o = '0;
    done_o      = '0;
    done_err_o  = RESP_OKAY;
    mgr_req_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && rstn_i) begin
          cmd_ready_o[grant] = 1'b1;
          owner_d = grant;
          addr_d  = cmd_addr_i[grant];
          count_d = cmd_count_i[grant];
          err_d   = RESP_OKAY;
          // Zero-count commands are never shown to the manager.
          state_d = (cmd_count_i[grant] == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        mgr_req_o = 1'b1;
        state_d   = BUSY;
      end
      BUSY: begin
        if (mgr_rsp_i) begin
          err_d   = mgr_err_i;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o[owner_q] = 1'b1;
        done_err_o      = err_q;
        rr_ptr_d = (owner_q == CID_W'(NUM_CLIENTS - 1)) ? '0 : owner_q + CID_W'(1);
        owner_d  = '0;
        addr_d   = '0;
        count_d  = '0;
        err_d    = RESP_OKAY;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign mgr_addr_o  = addr_q;
  assign mgr_count_o = count_q;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

`ifndef SYNTHESIS
  // A response outside BUSY is dropped by the FSM; flag it in simulation.
  a_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rstn_i)
    mgr_rsp_i |-> (state_q == BUSY));
`endif

endmodule

// File: rtl/axi4_mgr_sched.sv
// Shares one AXI4 manager between NUM_CLIENTS requesters; read and write
// are scheduled by two independent channel instances.
module axi4_mgr_sched
  import axi4_mgr_sched_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8,
  localparam int CID_W      = $clog2(NUM_CLIENTS)
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NUM_CLIENTS-1:0]              wr_cmd_valid_i,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  wr_cmd_addr_i,
  input  logic [NUM_CLIENTS-1:0][CNT_W-1:0]   wr_cmd_count_i,
  output logic [NUM_CLIENTS-1:0]              wr_cmd_ready_o,
  output logic [NUM_CLIENTS-1:0]              wr_done_o,
  output logic [1:0]                          wr_done_err_o,
  input  logic [NUM_CLIENTS-1:0]              rd_cmd_valid_i,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  rd_cmd_addr_i,
  input  logic [NUM_CLIENTS-1:0][CNT_W-1:0]   rd_cmd_count_i,
  output logic [NUM_CLIENTS-1:0]              rd_cmd_ready_o,
  output logic [NUM_CLIENTS-1:0]              rd_done_o,
  output logic [1:0]                          rd_done_err_o,
  output logic [1:0]                          mgr_req_o,
  output logic [ADDR_W-1:0]                   mgr_wr_addr_o,
  output logic [ADDR_W-1:0]                   mgr_rd_addr_o,
  output logic [CNT_W-1:0]                    mgr_wr_count_o,
  output logic [CNT_W-1:0]                    mgr_rd_count_o,
  input  logic [1:0]                          mgr_rsp_i,
  input  logic [1:0]                          mgr_wr_err_i,
  input  logic [1:0]                          mgr_rd_err_i,
  output logic                                wr_busy_o,
  output logic                                rd_busy_o,
  output logic [CID_W-1:0]                    wr_owner_o,
  output logic [CID_W-1:0]                    rd_owner_o
);

  axi4_mgr_sched_chan #(
    .NUM_CLIENTS(NUM_CLIENTS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) u_wr (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(wr_cmd_valid_i), .cmd_addr_i(wr_cmd_addr_i), .cmd_count_i(wr_cmd_count_i),
    .cmd_ready_o(wr_cmd_ready_o), .done_o(wr_done_o), .done_err_o(wr_done_err_o),
    .mgr_req_o(mgr_req_o[0]), .mgr_addr_o(mgr_wr_addr_o), .mgr_count_o(mgr_wr_count_o),
    .mgr_rsp_i(mgr_rsp_i[0]), .mgr_err_i(mgr_wr_err_i),
    .busy_o(wr_busy_o), .owner_o(wr_owner_o)
  );

  axi4_mgr_sched_chan #(
    .NUM_CLIENTS(NUM_CLIENTS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) u_rd (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(rd_cmd_valid_i), .cmd_addr_i(rd_cmd_addr_i), .cmd_count_i(rd_cmd_count_i),
    .cmd_ready_o(rd_cmd_ready_o), .done_o(rd_done_o), .done_err_o(rd_done_err_o),
    .mgr_req_o(mgr_req_o[1]), .mgr_addr_o(mgr_rd_addr_o), .mgr_count_o(mgr_rd_count_o),
    .mgr_rsp_i(mgr_rsp_i[1]), .mgr_err_i(mgr_rd_err_i),
    .busy_o(rd_busy_o), .owner_o(rd_owner_o)
  );

endmodule
